regfile_mp: RTL and testbench

//  Parametrised multi-port register file with scoreboard for the multi-issue CPU core.
//  - Sits between decode (read, reserve) and writeback (write, clear).
//  - Provides NUM_RD combinational read ports and NUM_WR synchronous write ports.
//  - Tracks one busy bit per register so issue logic can stall on pending producers.

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard for multi-issue issue/writeback.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         wen,
  input  logic [NUM_WR*ADDR_W-1:0]  waddr,
  input  logic [NUM_WR*DATA_W-1:0]  wdata,
  input  logic [NUM_RD*ADDR_W-1:0]  raddr,
  output logic [NUM_RD*DATA_W-1:0]  rdata,
  output logic [NUM_RD-1:0]         rbusy,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [ADDR_W:0]           busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  // Writes in ascending port order so the highest-index port wins a collision;
  // the reservation is applied last so a new producer outlives a same-cycle write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wen[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
        regs_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
        busy_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  genvar gj;
  generate
    for (gj = 0; gj < NUM_RD; gj++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;
      logic              rd_busy;

      assign ra = raddr[gj*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
      always_comb begin
        rd_val  = regs_q[ra];
        rd_busy = busy_q[ra];
        for (int k = 0; k < NUM_WR; k++) begin
          if (wen[k] && (waddr[k*ADDR_W +: ADDR_W] == ra) && (ra != '0)) begin
            rd_val  = wdata[k*DATA_W +: DATA_W];
            rd_busy = 1'b0;
          end
        end
      end
`else
      always_comb begin
        rd_val  = regs_q[ra];
        rd_busy = busy_q[ra];
      end
`endif

      // Outputs are held at zero for the whole reset, including any forwarded data.
      assign rdata[gj*DATA_W +: DATA_W] = rst ? '0 : rd_val;
      assign rbusy[gj]                  = rst ? 1'b0 : rd_busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed self-checking bench for regfile_mp against an array-based model.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk;
  logic                     rst;
  logic [NUM_WR-1:0]        wen;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W:0]          busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural model: plain register and busy arrays.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wen[k] && waddr[k*ADDR_W +: ADDR_W] != 0) begin
          m_mem[waddr[k*ADDR_W +: ADDR_W]]  <= wdata[k*DATA_W +: DATA_W];
          m_busy[waddr[k*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Compare process: on every falling edge, outputs vs. model.
  always @(negedge clk) begin
    if (chk_on) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
      check("busy_cnt", 64'(busy_cnt), rst ? 64'd0 : 64'(cnt));
      for (int j = 0; j < NUM_RD; j++) begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] ev;
        bit eb;
        a  = raddr[j*ADDR_W +: ADDR_W];
        ev = m_mem[a];
        eb = m_busy[a];
        if (BYPASS && a != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (wen[k] && waddr[k*ADDR_W +: ADDR_W] == a) begin
              ev = wdata[k*DATA_W +: DATA_W];
              eb = 1'b0;
            end
          end
        end
        if (rst) begin
          ev = '0;
          eb = 1'b0;
        end
        check($sformatf("rdata%0d", j), 64'(rdata[j*DATA_W +: DATA_W]), 64'(ev));
        check($sformatf("rbusy%0d", j), 64'(rbusy[j]), 64'(eb));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen    = '0;
    rsv_en = 1'b0;
  endtask

  initial begin
    rst = 0; wen = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 0; rsv_addr = '0;
    #2 rst = 1;
    #1 chk_on = 1;
    cyc(); cyc();
    rst = 0;

    // Async reset clears data and busy before any clock edge.
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h1234};
    rsv_en = 1; rsv_addr = 5'd6;
    cyc(); idle(); raddr = {5'd6, 5'd5};
    #1;
    check("t1_pre_rdata", 64'(rdata[31:0]), 64'h1234);
    check("t1_pre_cnt", 64'(busy_cnt), 64'd1);
    check("t1_pre_rbusy", 64'(rbusy[1]), 64'd1);
    rst = 1;
    #1;
    check("t1_rst_rdata", 64'(rdata[31:0]), 64'h0);
    check("t1_rst_rbusy", 64'(rbusy), 64'd0);
    check("t1_rst_cnt", 64'(busy_cnt), 64'd0);
    cyc(); rst = 0;

    // Both ports write r7: port 1 wins.
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'hBBBB, 32'hAAAA};
    cyc(); idle(); raddr = {5'd0, 5'd7};
    #1 check("t2_r7", 64'(rdata[31:0]), 64'hBBBB);

    // r0 writes and reservations are dropped.
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF};
    rsv_en = 1; rsv_addr = 5'd0; raddr = {5'd0, 5'd0};
    cyc(); idle();
    #1;
    check("t3_r0", 64'(rdata[31:0]), 64'h0);
    check("t3_rbusy", 64'(rbusy[0]), 64'd0);
    check("t3_cnt", 64'(busy_cnt), 64'd0);

    // Reserve r3, write it two cycles later.
    rsv_en = 1; rsv_addr = 5'd3;
    cyc(); idle(); raddr = {5'd0, 5'd3};
    #1;
    check("t4_busy_a", 64'(rbusy[0]), 64'd1);
    check("t4_cnt_a", 64'(busy_cnt), 64'd1);
    cyc();
    check("t4_busy_b", 64'(rbusy[0]), 64'd1);
    check("t4_cnt_b", 64'(busy_cnt), 64'd1);
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h55};
    cyc(); idle();
    #1;
    check("t4_busy_c", 64'(rbusy[0]), 64'd0);
    check("t4_cnt_c", 64'(busy_cnt), 64'd0);
    check("t4_rdata", 64'(rdata[31:0]), 64'h55);

    // Reserve and write r9 together: busy stays set.
    wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h77, 32'h0};
    rsv_en = 1; rsv_addr = 5'd9;
    cyc(); idle(); raddr = {5'd0, 5'd9};
    #1;
    check("t5_rdata", 64'(rdata[31:0]), 64'h77);
    check("t5_rbusy", 64'(rbusy[0]), 64'd1);
    check("t5_cnt", 64'(busy_cnt), 64'd1);

    // Same-cycle write and read of r4.
    wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h11};
    cyc();
    wdata = {32'h0, 32'h99}; raddr = {5'd0, 5'd4};
    #1;
    check("t6_same", 64'(rdata[31:0]), BYPASS ? 64'h99 : 64'h11);
    check("t6_same_busy", 64'(rbusy[0]), 64'd0);
    cyc(); idle();
    #1 check("t6_next", 64'(rdata[31:0]), 64'h99);

    // Randomized traffic, biased toward low addresses to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      cyc();
      rst = ($urandom_range(0, 60) == 0);
      wen = NUM_WR'($urandom);
      for (int k = 0; k < NUM_WR; k++) begin
        waddr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
        wdata[k*DATA_W +: DATA_W] = $urandom;
      end
      for (int j = 0; j < NUM_RD; j++)
        raddr[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom);
    end
    cyc(); rst = 0; idle();
    cyc(); cyc();
    chk_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
